mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - single-outstanding load/store unit between execute and a doubleword RAM port
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_en,
    output logic        ram_wen,
    output logic [63:0] ram_addr,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask,
    input  logic [63:0] ram_rdata,
    input  logic        ram_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Counter is at least 8 bits but grows for larger TIMEOUT values.
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    state_t        state_q, state_d;
    logic          wen_q, wen_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          err_q, err_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          misaligned;
    logic [63:0]   rd_shifted;
    logic [63:0]   load_ext;
    logic [7:0]    byte_en;
    logic [7:0]    byte_en_sh;
    logic [63:0]   mask_full;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    always_comb begin
        rd_shifted = ram_rdata >> {addr_q[2:0], 3'b000};
        load_ext   = rd_shifted;
        case (size_q)
            2'd0:    load_ext = uns_q ? {56'b0, rd_shifted[7:0]}
                                      : {{56{rd_shifted[7]}}, rd_shifted[7:0]};
            2'd1:    load_ext = uns_q ? {48'b0, rd_shifted[15:0]}
                                      : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            2'd2:    load_ext = uns_q ? {32'b0, rd_shifted[31:0]}
                                      : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            default: load_ext = rd_shifted;
        endcase
    end

    always_comb begin
        byte_en = 8'h00;
        case (size_q)
            2'd0:    byte_en = 8'h01;
            2'd1:    byte_en = 8'h03;
            2'd2:    byte_en = 8'h0F;
            default: byte_en = 8'hFF;
        endcase
        // Alignment is guaranteed in ACCESS, so the shifted lanes never overflow.
        byte_en_sh = byte_en << addr_q[2:0];
        mask_full  = '0;
        for (int i = 0; i < 8; i++) begin
            mask_full[i*8 +: 8] = {8{byte_en_sh[i]}};
        end
    end

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = misaligned;
                    state_d = misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                // An ack on the final allowed cycle still wins over the timeout.
                if (ram_ack) begin
                    rdata_d = wen_q ? 64'd0 : load_ext;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign ram_en     = (state_q == ACCESS);
    assign ram_wen    = ram_en & wen_q;
    assign ram_addr   = ram_en ? {addr_q[63:3], 3'b000} : 64'd0;
    assign ram_wdata  = ram_wen ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'd0;
    assign ram_wmask  = ram_wen ? mask_full : 64'd0;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid ? rdata_q : 64'd0;

endmodule
